// File: rtl/ee354_numlock_pkg.sv
// Shared types and helpers for the parametrised number-lock state machine.
package ee354_numlock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET     = 3'd1,
    GOOD    = 3'd2,
    OPENING = 3'd3,
    BAD     = 3'd4,
    LOCKOUT = 3'd5
  } numlock_state_t;

  // Width of a down-counter that holds values 0..n-1 (never narrower than 1 bit).
  function automatic int numlock_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ee354_numlock_timer.sv
// Loadable down-counter with a done flag; counts down to zero and holds there.
module ee354_numlock_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise decrement until zero, never wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ee354_numlock_param_sm.sv
// Parametrised number-lock FSM: CODE_LEN-digit binary combination on U/Z buttons.
// Optional failed-attempt counting and timed lockout when NUMLOCK_LOCKOUT_EN is defined.
module ee354_numlock_param_sm
  import ee354_numlock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  OPEN_CYCLES    = 16,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCKOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             U,
  input  logic                             Z,
  output logic                             Unlock,
  output logic [2:0]                       q_state,
  output logic [$clog2(CODE_LEN+1)-1:0]    digits_ok,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
  output logic                             locked_out
);

  localparam int DIG_W  = $clog2(CODE_LEN + 1);
  localparam int CNT_W  = numlock_cnt_w((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                       : LOCKOUT_CYCLES);

  numlock_state_t   state, state_n;
  logic             press, both, released, match, entering;
  logic [CODE_LEN-1:0] code_shift;
  logic [DIG_W-1:0] digits_inc;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  assign press      = U ^ Z;
  assign both       = U & Z;
  assign released   = ~U & ~Z;
  // Next expected digit sits at the MSB once the accepted digits are shifted out.
  assign code_shift = CODE << digits_ok;
  assign match      = (U == code_shift[CODE_LEN-1]);
  assign digits_inc = digits_ok + 1'b1;
  assign entering   = (state_n != state);
  assign q_state    = state;

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        // A leading wrong digit is ignored rather than treated as an error.
        if (both) state_n = BAD;
        else if (press && match) state_n = GET;
      end
      GET: begin
        if (released) state_n = (digits_inc == DIG_W'(CODE_LEN)) ? OPENING : GOOD;
      end
      GOOD: begin
        if (both) state_n = BAD;
        else if (press) state_n = match ? GET : BAD;
      end
      OPENING: begin
        if (tmr_done) state_n = IDLE;
      end
      BAD: begin
        if (released) begin
`ifdef NUMLOCK_LOCKOUT_EN
          state_n = (fail_count == $bits(fail_count)'(MAX_TRIES)) ? LOCKOUT : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef NUMLOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_done) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Shared timer is loaded on entry to whichever timed state comes next.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(OPEN_CYCLES - 1);
    if (entering && state_n == OPENING) tmr_load = 1'b1;
`ifdef NUMLOCK_LOCKOUT_EN
    if (entering && state_n == LOCKOUT) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(LOCKOUT_CYCLES - 1);
    end
`endif
  end

  ee354_numlock_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  // State register and registered Moore Unlock output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      Unlock <= 1'b0;
    end else begin
      state  <= state_n;
      Unlock <= (state_n == OPENING);
    end
  end

  // Digit index: counts on each completed correct digit; the full count is
  // visible for the first OPENING cycle, then cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_ok <= '0;
    end else if (state == GET && released) begin
      digits_ok <= digits_inc;
    end else if (state == OPENING || (entering && state_n == BAD)) begin
      digits_ok <= '0;
    end
  end

`ifdef NUMLOCK_LOCKOUT_EN
  // Consecutive-failure counter: saturating increment on each BAD entry,
  // cleared by a successful open or by the end of a lockout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_count <= '0;
    end else if (entering && state_n == BAD) begin
      if (fail_count != $bits(fail_count)'(MAX_TRIES)) fail_count <= fail_count + 1'b1;
    end else if (entering && state_n == OPENING) begin
      fail_count <= '0;
    end else if (state == LOCKOUT && state_n == IDLE) begin
      fail_count <= '0;
    end
  end

  // Registered lockout indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) locked_out <= 1'b0;
    else        locked_out <= (state_n == LOCKOUT);
  end
`else
  assign fail_count = '0;
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_ee354_numlock_param_sm.sv
// Self-checking bench for ee354_numlock_param_sm (CODE=1011, OPEN=8, MAX_TRIES=3, LOCKOUT=20).
// Expectations follow NUMLOCK_LOCKOUT_EN when defined.
`timescale 1ns/1ps
module tb_ee354_numlock_param_sm;

  localparam int OPEN_N = 8;
  localparam int LOCK_N = 20;
  localparam int MAXT   = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_GET = 3'd1, S_GOOD = 3'd2, S_BAD = 3'd4;
`ifdef NUMLOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       U = 1'b0;
  logic       Z = 1'b0;
  logic       Unlock;
  logic [2:0] q_state;
  logic [2:0] digits_ok;
  logic [1:0] fail_count;
  logic       locked_out;

  int errors = 0;
  int checks = 0;
  int unl_cnt = 0;
  int lock_cnt = 0;

  // Reference model state: digits accepted so far and consecutive failures.
  int code_bits[4] = '{1, 0, 1, 1};
  int m_prog = 0;
  int m_fails = 0;

  ee354_numlock_param_sm #(
    .CODE_LEN(4), .CODE(4'b1011), .OPEN_CYCLES(OPEN_N),
    .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCK_N)
  ) dut (
    .clk(clk), .reset(reset), .U(U), .Z(Z), .Unlock(Unlock), .q_state(q_state),
    .digits_ok(digits_ok), .fail_count(fail_count), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  // Advance one clock; observe just after the edge and tally high cycles.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (Unlock === 1'b1) unl_cnt++;
    if (locked_out === 1'b1) lock_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b0; U = 1'b0; Z = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    m_prog = 0; m_fails = 0;
  endtask

  task automatic digit(input int d, input int plen, input int rlen);
    U = (d == 1); Z = (d == 0);
    repeat (plen) cyc();
    U = 1'b0; Z = 1'b0;
    repeat (rlen) cyc();
  endtask

  task automatic enter_code(input int plen, input int rlen);
    for (int i = 0; i < 4; i++) digit(code_bits[i], plen, rlen);
  endtask

  // Episode-level model: one press-and-release of kind 0 (Z), 1 (U) or 2 (both).
  // outcome: 0 accepted/ignored, 1 opens, 2 error, 3 error that starts lockout.
  task automatic model_episode(input int kind, output int outcome);
    outcome = 0;
    if (kind == 2) outcome = 2;
    else if (kind == code_bits[m_prog]) begin
      m_prog++;
      if (m_prog == 4) begin outcome = 1; m_prog = 0; m_fails = 0; end
    end else if (m_prog != 0) outcome = 2;
    if (outcome == 2) begin
      m_prog = 0;
      if (LOCK_EN) begin
        if (m_fails < MAXT) m_fails++;
        if (m_fails == MAXT) begin outcome = 3; m_fails = 0; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; U = 1'b1; Z = 1'b0;
    repeat (2) cyc();
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", q_state, S_IDLE); end
    checks++; if (Unlock !== 1'b0) begin errors++; $display("FAIL reset_unlock got=%b exp=0", Unlock); end
    checks++; if (digits_ok !== 3'd0) begin errors++; $display("FAIL reset_digits got=%0d exp=0", digits_ok); end
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL reset_fails got=%0d exp=0", fail_count); end
    checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked_out); end
    U = 1'b0;
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_correct_code();
    int streak;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      digit(code_bits[i], 5, 1);
      checks++; if (digits_ok !== 3'(i + 1)) begin errors++; $display("FAIL code_digits[%0d] got=%0d exp=%0d", i, digits_ok, i + 1); end
      checks++; if (q_state !== S_GOOD) begin errors++; $display("FAIL code_good[%0d] got=%0d exp=%0d", i, q_state, S_GOOD); end
      repeat (2) cyc();
    end
    digit(code_bits[3], 5, 0);
    cyc();
    checks++; if (Unlock !== 1'b1) begin errors++; $display("FAIL unlock_rise got=%b exp=1", Unlock); end
    checks++; if (digits_ok !== 3'd4) begin errors++; $display("FAIL digits_full got=%0d exp=4", digits_ok); end
    streak = 0;
    for (int i = 0; i < 40; i++) begin
      if (Unlock !== 1'b1) break;
      streak++;
      cyc();
    end
    checks++; if (streak !== OPEN_N) begin errors++; $display("FAIL unlock_len got=%0d exp=%0d", streak, OPEN_N); end
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL after_open_state got=%0d exp=%0d", q_state, S_IDLE); end
    checks++; if (digits_ok !== 3'd0) begin errors++; $display("FAIL after_open_digits got=%0d exp=0", digits_ok); end
    U = 1'b1;
    cyc();
    checks++; if (q_state !== S_GET) begin errors++; $display("FAIL press_after_open got=%0d exp=%0d", q_state, S_GET); end
    U = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_leading_wrong();
    int u0;
    do_reset();
    Z = 1'b1;
    repeat (4) cyc();
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL lead_z_state got=%0d exp=%0d", q_state, S_IDLE); end
    checks++; if (digits_ok !== 3'd0) begin errors++; $display("FAIL lead_z_digits got=%0d exp=0", digits_ok); end
    Z = 1'b0;
    repeat (2) cyc();
    u0 = unl_cnt;
    enter_code(5, 3);
    repeat (10) cyc();
    checks++; if (unl_cnt - u0 !== OPEN_N) begin errors++; $display("FAIL lead_z_unlock got=%0d exp=%0d", unl_cnt - u0, OPEN_N); end
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL lead_z_fails got=%0d exp=0", fail_count); end
  endtask

  task automatic test_wrong_last();
    int u0;
    do_reset();
    u0 = unl_cnt;
    for (int i = 0; i < 3; i++) digit(code_bits[i], 5, 3);
    Z = 1'b1;
    cyc();
    checks++; if (q_state !== S_BAD) begin errors++; $display("FAIL wrong_last_bad got=%0d exp=%0d", q_state, S_BAD); end
    checks++; if (digits_ok !== 3'd0) begin errors++; $display("FAIL wrong_last_digits got=%0d exp=0", digits_ok); end
    checks++; if (fail_count !== 2'(LOCK_EN ? 1 : 0)) begin errors++; $display("FAIL wrong_last_fails got=%0d exp=%0d", fail_count, LOCK_EN ? 1 : 0); end
    repeat (4) cyc();
    Z = 1'b0;
    cyc();
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL wrong_last_idle got=%0d exp=%0d", q_state, S_IDLE); end
    repeat (15) cyc();
    checks++; if (unl_cnt !== u0) begin errors++; $display("FAIL wrong_last_unlock got=%0d exp=0", unl_cnt - u0); end
  endtask

  task automatic test_both_in_good();
    int bad_cycles;
    do_reset();
    digit(1, 3, 2);
    U = 1'b1; Z = 1'b1;
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (q_state === S_BAD) bad_cycles++;
    end
    checks++; if (bad_cycles !== 10) begin errors++; $display("FAIL both_hold_bad got=%0d exp=10", bad_cycles); end
    U = 1'b0; Z = 1'b0;
    cyc();
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL both_release_idle got=%0d exp=%0d", q_state, S_IDLE); end
    checks++; if (fail_count !== 2'(LOCK_EN ? 1 : 0)) begin errors++; $display("FAIL both_fails got=%0d exp=%0d", fail_count, LOCK_EN ? 1 : 0); end
  endtask

  task automatic test_lockout();
    int u0, l0;
    do_reset();
    u0 = unl_cnt; l0 = lock_cnt;
    for (int f = 0; f < 3; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        U = 1'b1; Z = 1'b1;
      end else begin
        digit(1, 2, 2);
        U = 1'b1; Z = 1'b0;
      end
      repeat (2) cyc();
      U = 1'b0; Z = 1'b0;
      cyc();
      if (f == 2) begin
        checks++; if (locked_out !== LOCK_EN) begin errors++; $display("FAIL lockout_start got=%b exp=%b", locked_out, LOCK_EN); end
      end
      cyc();
    end
    enter_code(2, 2);
    repeat (25) cyc();
    checks++; if (lock_cnt - l0 !== (LOCK_EN ? LOCK_N : 0)) begin errors++; $display("FAIL lockout_len got=%0d exp=%0d", lock_cnt - l0, LOCK_EN ? LOCK_N : 0); end
    checks++; if (unl_cnt - u0 !== (LOCK_EN ? 0 : OPEN_N)) begin errors++; $display("FAIL lockout_unlock got=%0d exp=%0d", unl_cnt - u0, LOCK_EN ? 0 : OPEN_N); end
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL lockout_fails got=%0d exp=0", fail_count); end
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL lockout_idle got=%0d exp=%0d", q_state, S_IDLE); end
  endtask

  task automatic test_reset_in_opening();
    int u0;
    do_reset();
    enter_code(3, 3);
    checks++; if (Unlock !== 1'b1) begin errors++; $display("FAIL opening_before_reset got=%b exp=1", Unlock); end
    #2 reset = 1'b0;
    #1;
    checks++; if (Unlock !== 1'b0) begin errors++; $display("FAIL async_reset_unlock got=%b exp=0", Unlock); end
    checks++; if (q_state !== S_IDLE) begin errors++; $display("FAIL async_reset_state got=%0d exp=%0d", q_state, S_IDLE); end
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    u0 = unl_cnt;
    enter_code(3, 2);
    repeat (12) cyc();
    checks++; if (unl_cnt - u0 !== OPEN_N) begin errors++; $display("FAIL reopen_len got=%0d exp=%0d", unl_cnt - u0, OPEN_N); end
  endtask

  task automatic test_random();
    int kind, outc, plen, rlen, u0, l0;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) kind = code_bits[m_prog];
      else kind = $urandom_range(0, 2);
      plen = $urandom_range(1, 4);
      rlen = $urandom_range(1, 3);
      u0 = unl_cnt; l0 = lock_cnt;
      model_episode(kind, outc);
      U = (kind != 0); Z = (kind != 1);
      repeat (plen) cyc();
      U = 1'b0; Z = 1'b0;
      repeat (rlen) cyc();
      if (outc == 1 || outc == 3) repeat (25) cyc();
      checks++; if (digits_ok !== 3'(m_prog)) begin errors++; $display("FAIL rand_digits[%0d] got=%0d exp=%0d", n, digits_ok, m_prog); end
      checks++; if (fail_count !== 2'(m_fails)) begin errors++; $display("FAIL rand_fails[%0d] got=%0d exp=%0d", n, fail_count, m_fails); end
      checks++; if (q_state !== (m_prog == 0 ? S_IDLE : S_GOOD)) begin errors++; $display("FAIL rand_state[%0d] got=%0d exp=%0d", n, q_state, m_prog == 0 ? S_IDLE : S_GOOD); end
      checks++; if (unl_cnt - u0 !== (outc == 1 ? OPEN_N : 0)) begin errors++; $display("FAIL rand_unlock[%0d] got=%0d exp=%0d", n, unl_cnt - u0, outc == 1 ? OPEN_N : 0); end
      checks++; if (lock_cnt - l0 !== (outc == 3 ? LOCK_N : 0)) begin errors++; $display("FAIL rand_lock[%0d] got=%0d exp=%0d", n, lock_cnt - l0, outc == 3 ? LOCK_N : 0); end
    end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_leading_wrong();
    test_wrong_last();
    test_both_in_good();
    test_lockout();
    test_reset_in_opening();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ee354_numlock_param_sm.md
# ee354_numlock_param_sm

- Parametrised successor to the fixed four-digit number-lock state machine.
- Accepts a CODE_LEN-digit binary combination entered on two buttons: U = digit 1, Z = digit 0.
- Each digit counts only after press-and-release.
- On a correct combination, asserts Unlock for a programmable number of cycles; on an error, waits for both buttons to be released.
- Optionally counts failed attempts and enforces a timed lockout.
- Sits between the debounced button synchronisers and the door-actuator/LED logic of the numlock top level.

## Interface
- CODE_LEN, 4: number of digits in the combination (1..16).
- CODE, 4'b1011: combination, CODE_LEN bits; MSB is entered first.
- OPEN_CYCLES, 16: cycles Unlock stays high (≥1).
- MAX_TRIES, 3: consecutive failures that trigger lockout (≥1).
- LOCKOUT_CYCLES, 64: lockout duration in cycles (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- U  in  1  "1" button, synchronised, level.
- Z  in  1  "0" button, synchronised, level.
- Unlock  out  1  registered; high only in OPENING.
- q_state  out  3  current state code from package enum.
- digits_ok  out  $clog2(CODE_LEN+1)  number of correct digits accepted so far.
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive failed attempts.
- locked_out  out  1  high only in LOCKOUT.

## Operation
- States: IDLE, GET, GOOD, OPENING, BAD, LOCKOUT.
- Define press = U^Z, both = U&Z, released = ~U&~Z, and digit = U.
- Expected digit e = CODE[CODE_LEN-1-digits_ok].
- IDLE (digits_ok=0):
  - both → BAD.
  - Press with digit==e → GET.
  - Press with digit!=e → remain IDLE, ignored; this preserves the legacy behaviour of ignoring a leading wrong digit.
- GET: waits in place until released, then digits_ok+1.
  - If the new count equals CODE_LEN → OPENING.
  - Otherwise → GOOD.
- GOOD:
  - both → BAD.
  - Press with digit==e → GET.
  - Press with digit!=e → BAD.
  - released → stay.
- OPENING:
  - Inputs ignored.
  - Down-counter loads OPEN_CYCLES-1 on entry; → IDLE when it reaches 0.
  - digits_ok and fail_count clear on entry.
- BAD:
  - fail_count increments on entry, saturating at MAX_TRIES.
  - digits_ok clears on entry.
  - When released → IDLE, or → LOCKOUT (see Configuration).
- LOCKOUT:
  - Inputs ignored; counter runs LOCKOUT_CYCLES.
  - Then → IDLE with fail_count=0.
- A press held across the GET→GOOD boundary is impossible, because GET exits only on release.
- Reset mid-operation (including OPENING/LOCKOUT) aborts immediately to IDLE.

## Timing
- Reset values: q_state=IDLE, Unlock=0, digits_ok=0, fail_count=0, locked_out=0, counters=0.
- All outputs are registered Moore outputs; no combinational input→output path.
- Unlock rises the cycle after the final release is sampled.
- Unlock is high for exactly OPEN_CYCLES consecutive cycles.
- After Unlock falls, IDLE is entered on the same edge; a press sampled on the next cycle is accepted.
- Wrong-digit/both detection → BAD takes one edge; BAD → IDLE takes one edge after released is sampled.
- Counters are sized $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)); no wrap-around (loaded and decremented to 0 only).

## Configuration
- NUMLOCK_LOCKOUT_EN defined:
  - BAD exits to LOCKOUT instead of IDLE when the incremented fail_count == MAX_TRIES.
  - locked_out is asserted for LOCKOUT_CYCLES cycles.
- Undefined:
  - The LOCKOUT state and its counter are not generated; BAD always exits to IDLE.
  - fail_count is tied to 0 and locked_out to 0.
  - MAX_TRIES and LOCKOUT_CYCLES are unused.

## Structure
- Package ee354_numlock_pkg:
  - State enum numlock_state_t (3-bit, encodings IDLE=0 … LOCKOUT=5).
  - Function numlock_cnt_w(n) returning the counter width.
- One sub-module, ee354_numlock_timer: loadable down-counter with a done flag.
  - Instanced once, shared by OPENING and LOCKOUT; load value is selected by the next state.
- Top holds the state register, digit index and fail counter.

## Test plan
All scenarios use CODE_LEN=4, CODE=4'b1011, OPEN_CYCLES=8, MAX_TRIES=3, LOCKOUT_CYCLES=20.
- Enter 1,0,1,1, each as a 5-cycle press and 3-cycle release → Unlock high exactly 8 cycles starting one cycle after the 4th release; digits_ok 1,2,3,4 then 0.
- Z pressed in IDLE, then 1,0,1,1 → Z ignored, unlock occurs; fail_count stays 0.
- Enter 1,0,1,0 → BAD on the 4th press; IDLE after release; fail_count=1; Unlock never high.
- U and Z pressed together in GOOD → BAD; hold both 10 cycles → remains BAD until both released.
- Three consecutive failures with NUMLOCK_LOCKOUT_EN:
  - → locked_out high 20 cycles.
  - A correct code entered during lockout is ignored; afterwards fail_count=0.
  - Without the macro → no lockout, fail_count=0.
- Assert reset=0 midway through OPENING → Unlock drops asynchronously; q_state=IDLE; after release the next correct code opens normally.
